// File: rtl/vga_frame_reader.sv
// vga_frame_reader: VGA scan-out engine on the read side of the frame buffer.
// Generates VGA timing, walks the stored image with integer upscaling inside a
// placeable window, and returns RGB332 buffer data as RGB444 with aligned syncs.
// Optional build macro VGA_FRAME_READER_REPLICATE_EN: RGB332 -> RGB444 by MSB
// replication; when undefined the low bits are zero-filled.
module vga_frame_reader #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned IMG_W      = 320,
  parameter int unsigned IMG_H      = 240,
  parameter int unsigned SCALE_LOG2 = 1,
  parameter int unsigned X_OFF      = 0,
  parameter int unsigned Y_OFF      = 0,
  parameter int unsigned AW         = 17,
  parameter int unsigned DW         = 8,
  parameter int unsigned RD_LAT     = 1,
  parameter logic [7:0]  BORDER     = 8'h00
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          VGA_Hsync_n,
  output logic          VGA_Vsync_n,
  output logic [3:0]    VGA_R,
  output logic [3:0]    VGA_G,
  output logic [3:0]    VGA_B,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned X_END    = X_OFF + (IMG_W << SCALE_LOG2);
  localparam int unsigned Y_END    = Y_OFF + (IMG_H << SCALE_LOG2);
  localparam int unsigned SW       = (SCALE_LOG2 == 0) ? 1 : SCALE_LOG2;
  localparam int unsigned NST      = RD_LAT + 1;
  localparam int unsigned FW       = 5;

  // Flag positions inside one pipeline stage
  localparam int unsigned F_WIN = 0;
  localparam int unsigned F_ACT = 1;
  localparam int unsigned F_HS  = 2;
  localparam int unsigned F_VS  = 3;
  localparam int unsigned F_FS  = 4;

  localparam logic [SW-1:0] SUB_MAX = SW'((1 << SCALE_LOG2) - 1);
  localparam logic [AW-1:0] PARK    = AW'(IMG_W * IMG_H);
  localparam logic [AW-1:0] ROW_INC = AW'(IMG_W);

  // Parameter sanity, caught at elaboration
  if (SCALE_LOG2 > 2) begin : g_bad_scale
    $error("vga_frame_reader: SCALE_LOG2 must be 0, 1 or 2");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
    $error("vga_frame_reader: RD_LAT must be 1..3");
  end
  if (DW != 8) begin : g_bad_dw
    $error("vga_frame_reader: DW must be 8 (RGB332)");
  end
  if ((64'(IMG_W) * 64'(IMG_H) + 64'd1) > (64'd1 << AW)) begin : g_bad_aw
    $error("vga_frame_reader: AW too small for image plus park address");
  end

  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic [AW-1:0]     row_base;
  logic [AW-1:0]     col;
  logic [SW-1:0]     px;
  logic [SW-1:0]     sub;
  logic [NST-1:0][FW-1:0] pipe;

  logic h_last, v_last, act, x_lo, y_lo, x_in, y_in, win, hs, vs, fs;
  logic [FW-1:0] tail;
  logic [7:0]    pix;
  logic [3:0]    r4, g4, b4;

  // Lower window edges; a zero offset needs no comparison
  if (X_OFF == 0) begin : g_x0
    assign x_lo = 1'b1;
  end else begin : g_x1
    assign x_lo = (32'(h_cnt) >= X_OFF);
  end
  if (Y_OFF == 0) begin : g_y0
    assign y_lo = 1'b1;
  end else begin : g_y1
    assign y_lo = (32'(v_cnt) >= Y_OFF);
  end

  // Decode the current scan position into region and sync flags
  always_comb begin
    h_last = (32'(h_cnt) == H_TOTAL - 1);
    v_last = (32'(v_cnt) == V_TOTAL - 1);
    act    = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
    x_in   = x_lo && (32'(h_cnt) < X_END) && (32'(h_cnt) < H_ACTIVE);
    y_in   = y_lo && (32'(v_cnt) < Y_END) && (32'(v_cnt) < V_ACTIVE);
    win    = x_in && y_in;
    hs     = (32'(h_cnt) >= HS_START) && (32'(h_cnt) < HS_END);
    vs     = (32'(v_cnt) >= VS_START) && (32'(v_cnt) < VS_END);
    fs     = (h_cnt == '0) && (v_cnt == '0);
  end

  // Horizontal / vertical scan counters; en low parks them at (0,0)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Incremental read address: column steps every 2^SCALE_LOG2 pixels,
  // row base steps by IMG_W every 2^SCALE_LOG2 in-window lines
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr <= '0;
      row_base <= '0;
      col      <= '0;
      px       <= '0;
      sub      <= '0;
    end else if (!en) begin
      mem_addr <= '0;
      row_base <= '0;
      col      <= '0;
      px       <= '0;
      sub      <= '0;
    end else begin
      mem_addr <= win ? (row_base + col) : PARK;
      if (win) begin
        if (px == SUB_MAX) begin
          px  <= '0;
          col <= col + 1'b1;
        end else begin
          px <= px + 1'b1;
        end
      end else begin
        px  <= '0;
        col <= '0;
      end
      if (h_last) begin
        if (v_last) begin
          row_base <= '0;
          sub      <= '0;
        end else if (y_in) begin
          if (sub == SUB_MAX) begin
            sub      <= '0;
            row_base <= row_base + ROW_INC;
          end else begin
            sub <= sub + 1'b1;
          end
        end
      end
    end
  end

  // Delay the position flags to line up with the returning buffer data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe <= '0;
    end else if (!en) begin
      pipe <= '0;
    end else begin
      pipe[0] <= {fs, vs, hs, act, win};
      for (int i = 1; i < int'(NST); i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // Select the displayed byte and expand RGB332 to RGB444
  always_comb begin
    tail = pipe[NST-1];
    pix  = 8'h00;
    if (tail[F_WIN]) begin
      pix = mem_data[7:0];
    end else if (tail[F_ACT]) begin
      pix = BORDER;
    end
`ifdef VGA_FRAME_READER_REPLICATE_EN
    r4 = {pix[7:5], pix[7]};
    g4 = {pix[4:2], pix[4]};
    b4 = {pix[1:0], pix[1:0]};
`else
    r4 = {pix[7:5], 1'b0};
    g4 = {pix[4:2], 1'b0};
    b4 = {pix[1:0], 2'b00};
`endif
  end

  // Pin register: colour, syncs and frame marker leave together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      VGA_Hsync_n <= 1'b1;
      VGA_Vsync_n <= 1'b1;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      frame_start <= 1'b0;
    end else if (!en) begin
      VGA_Hsync_n <= 1'b1;
      VGA_Vsync_n <= 1'b1;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      frame_start <= 1'b0;
    end else begin
      VGA_Hsync_n <= ~tail[F_HS];
      VGA_Vsync_n <= ~tail[F_VS];
      VGA_R       <= r4;
      VGA_G       <= g4;
      VGA_B       <= b4;
      frame_start <= tail[F_FS];
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader: four instances cover default timing,
// a reduced-geometry 2x full screen, an offset 1x window with border, and a
// three-clock read latency. Model RAMs return addr[7:0] (or constant 8'hFF).
module tb_vga_frame_reader;

  // Expected RGB444 (packed R,G,B) for the bytes used below
`ifdef VGA_FRAME_READER_REPLICATE_EN
  localparam int E_FF = 'hFFF;
  localparam int E_E0 = 'hF00;
  localparam int E_02 = 'h00A;
  localparam int E_2A = 'h24A;
  localparam int E_54 = 'h4B0;
`else
  localparam int E_FF = 'hEEC;
  localparam int E_E0 = 'hE00;
  localparam int E_02 = 'h008;
  localparam int E_2A = 'h248;
  localparam int E_54 = 'h4A0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic en_a;
  logic en_on;
  int   cyc;
  int   total = 0;
  int   bad   = 0;

  logic [16:0] a_addr;
  logic [7:0]  a_data;
  logic        a_hs, a_vs, a_fs;
  logic [3:0]  a_r, a_g, a_b;

  logic [11:0] b_addr;
  logic [7:0]  b_data;
  logic        b_hs, b_vs, b_fs;
  logic [3:0]  b_r, b_g, b_b;

  logic [11:0] c_addr;
  logic [7:0]  c_data;
  logic        c_hs, c_vs, c_fs;
  logic [3:0]  c_r, c_g, c_b;

  logic [11:0] d_addr;
  logic [7:0]  d_data, d_p1, d_p2;
  logic        d_hs, d_vs, d_fs;
  logic [3:0]  d_r, d_g, d_b;

  always #20 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Model RAMs
  always @(posedge clk) a_data <= a_addr[7:0];
  always @(posedge clk) begin
    d_p1   <= d_addr[7:0];
    d_p2   <= d_p1;
    d_data <= d_p2;
  end
  assign b_data = 8'h00;
  assign c_data = 8'hFF;

  vga_frame_reader u_a (
    .clk(clk), .rst(rst), .en(en_a), .mem_addr(a_addr), .mem_data(a_data),
    .VGA_Hsync_n(a_hs), .VGA_Vsync_n(a_vs), .VGA_R(a_r), .VGA_G(a_g),
    .VGA_B(a_b), .frame_start(a_fs));

  vga_frame_reader #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .IMG_W(32), .IMG_H(24), .SCALE_LOG2(1), .AW(12)
  ) u_b (
    .clk(clk), .rst(rst), .en(en_on), .mem_addr(b_addr), .mem_data(b_data),
    .VGA_Hsync_n(b_hs), .VGA_Vsync_n(b_vs), .VGA_R(b_r), .VGA_G(b_g),
    .VGA_B(b_b), .frame_start(b_fs));

  vga_frame_reader #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .IMG_W(16), .IMG_H(12), .SCALE_LOG2(0), .X_OFF(10), .Y_OFF(5),
    .AW(12), .BORDER(8'hE0)
  ) u_c (
    .clk(clk), .rst(rst), .en(en_on), .mem_addr(c_addr), .mem_data(c_data),
    .VGA_Hsync_n(c_hs), .VGA_Vsync_n(c_vs), .VGA_R(c_r), .VGA_G(c_g),
    .VGA_B(c_b), .frame_start(c_fs));

  vga_frame_reader #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .IMG_W(32), .IMG_H(24), .SCALE_LOG2(1), .AW(12), .RD_LAT(3)
  ) u_d (
    .clk(clk), .rst(rst), .en(en_on), .mem_addr(d_addr), .mem_data(d_data),
    .VGA_Hsync_n(d_hs), .VGA_Vsync_n(d_vs), .VGA_R(d_r), .VGA_G(d_g),
    .VGA_B(d_b), .frame_start(d_fs));

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h) at cyc %0d",
               tag, got, got, exp, exp, cyc);
    end
  endtask

  // Cycle k = state after the k-th rising edge since reset release
  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  // Default 640x480 instance: addresses, syncs, frame marker, en drop
  task automatic run_a();
    int f1, c1, f2;
    bit found;
    for (int x = 0; x < 640; x++) begin
      wait_cyc(x + 1);
      chk($sformatf("a_l0_x%0d", x), int'(a_addr), x >> 1);
      if (x == 1) chk("a_fs_early", int'(a_fs), 0);
      if (x == 2) chk("a_fs_pulse", int'(a_fs), 1);
      if (x == 3) chk("a_fs_after", int'(a_fs), 0);
      if (x == 7) chk("a_rgb_px5", int'({a_r, a_g, a_b}), E_02);
    end
    wait_cyc(648);
    chk("a_blank_rgb", int'({a_r, a_g, a_b}), 0);
    chk("a_blank_vs", int'(a_vs), 1);
    f1 = 0; found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (!a_hs) begin found = 1; f1 = cyc; end
    end
    chk("a_hs_fall", f1, 656 + 1 + 2);
    c1 = 0; found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (a_hs) begin found = 1; c1 = cyc; end
    end
    chk("a_hs_low_len", c1 - f1, 96);
    for (int x = 0; x < 640; x++) begin
      wait_cyc(800 + x + 1);
      chk($sformatf("a_l1_x%0d", x), int'(a_addr), x >> 1);
    end
    f2 = 0; found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (!a_hs) begin found = 1; f2 = cyc; end
    end
    chk("a_hs_period", f2 - f1, 800);
    for (int x = 0; x < 300; x++) begin
      wait_cyc(1600 + x + 1);
      chk($sformatf("a_l2_x%0d", x), int'(a_addr), 320 + (x >> 1));
    end
    // Scan sits at (300,2); drop en for ten clocks
    en_a = 1'b0;
    wait_cyc(1905);
    chk("a_off_rgb", int'({a_r, a_g, a_b}), 0);
    chk("a_off_hs", int'(a_hs), 1);
    chk("a_off_vs", int'(a_vs), 1);
    chk("a_off_fs", int'(a_fs), 0);
    wait_cyc(1910);
    en_a = 1'b1;
    wait_cyc(1912);
    chk("a_re_fs_early", int'(a_fs), 0);
    chk("a_re_addr_px1", int'(a_addr), 0);
    wait_cyc(1913);
    chk("a_re_fs_pulse", int'(a_fs), 1);
    chk("a_re_addr_px2", int'(a_addr), 1);
    wait_cyc(1918);
    chk("a_re_rgb_px5", int'({a_r, a_g, a_b}), E_02);
  endtask

  // Reduced geometry, 2x full screen: last pixel, vsync, frame wrap
  task automatic run_b();
    wait_cyc(65);   chk("b_park", int'(b_addr), 768);
    wait_cyc(82);   chk("b_px_1_1", int'(b_addr), 0);
    wait_cyc(163);  chk("b_px_2_2", int'(b_addr), 33);
    wait_cyc(3761); chk("b_px_0_47", int'(b_addr), 736);
    wait_cyc(3824); chk("b_px_63_47", int'(b_addr), 767);
    wait_cyc(4002); chk("b_vs_before", int'(b_vs), 1);
    wait_cyc(4003); chk("b_vs_low", int'(b_vs), 0);
    wait_cyc(4321); chk("b_f2_px0", int'(b_addr), 0);
    wait_cyc(4322); chk("b_f2_fs_early", int'(b_fs), 0);
    wait_cyc(4323);
    chk("b_f2_fs", int'(b_fs), 1);
    chk("b_f2_px2", int'(b_addr), 1);
  endtask

  // Offset 1x window with red border, RAM returns 8'hFF
  task automatic run_c();
    wait_cyc(410);  chk("c_park_9_5", int'(c_addr), 192);
    wait_cyc(411);  chk("c_px_10_5", int'(c_addr), 0);
    wait_cyc(412);  chk("c_rgb_9_5", int'({c_r, c_g, c_b}), E_E0);
    wait_cyc(413);  chk("c_rgb_10_5", int'({c_r, c_g, c_b}), E_FF);
    wait_cyc(428);  chk("c_rgb_25_5", int'({c_r, c_g, c_b}), E_FF);
    wait_cyc(429);  chk("c_rgb_26_5", int'({c_r, c_g, c_b}), E_E0);
    wait_cyc(473);  chk("c_rgb_70_5", int'({c_r, c_g, c_b}), 0);
    wait_cyc(491);  chk("c_px_10_6", int'(c_addr), 16);
    wait_cyc(1306); chk("c_px_25_16", int'(c_addr), 191);
    wait_cyc(1373); chk("c_rgb_10_17", int'({c_r, c_g, c_b}), E_E0);
  endtask

  // Three-clock read latency: pins trail the counters by five clocks
  task automatic run_d();
    wait_cyc(4);   chk("d_fs_early", int'(d_fs), 0);
    wait_cyc(5);   chk("d_fs_pulse", int'(d_fs), 1);
    wait_cyc(72);  chk("d_hs_before", int'(d_hs), 1);
    wait_cyc(73);  chk("d_hs_low", int'(d_hs), 0);
    wait_cyc(265); chk("d_rgb_20_3", int'({d_r, d_g, d_b}), E_2A);
    wait_cyc(445); chk("d_rgb_40_5", int'({d_r, d_g, d_b}), E_54);
  endtask

  initial begin
    rst   = 1'b0;
    en_a  = 1'b1;
    en_on = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_a_hs", int'(a_hs), 1);
    chk("rst_a_vs", int'(a_vs), 1);
    chk("rst_a_rgb", int'({a_r, a_g, a_b}), 0);
    chk("rst_a_addr", int'(a_addr), 0);
    chk("rst_a_fs", int'(a_fs), 0);
    chk("rst_c_rgb", int'({c_r, c_g, c_b}), 0);
    chk("rst_d_hs", int'(d_hs), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    fork
      run_a();
      run_b();
      run_c();
      run_d();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(40 * 20000);
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
